// File: rtl/ibus_imem_responder_pkg.sv
// Shared ibus types, fetch reset vector and instruction-memory defaults.
package ibus_imem_responder_pkg;

    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    localparam u64          PCINIT             = 64'h0000_0000_8000_0000;
    localparam int unsigned IMEM_WORDS_DEFAULT = 32'd1024;

    typedef struct packed {
        logic valid;
        u64   addr;
    } ibus_req_t;

    typedef struct packed {
        logic addr_ok;
        logic data_ok;
        u32   data;
    } ibus_resp_t;

endpackage

// File: rtl/ibus_imem_responder_if.sv
// ibus fetch handshake bundle: request from the fetch stage, response and fault back.
interface ibus_imem_responder_if;
    import ibus_imem_responder_pkg::*;

    ibus_req_t  ibus_req;
    ibus_resp_t ibus_resp;
    logic       fault;

    modport master (output ibus_req, input ibus_resp, input fault);
    modport slave  (input ibus_req, output ibus_resp, output fault);

endinterface

// File: rtl/ibus_imem_responder_bank.sv
// Instruction word array: synchronous load write port, asynchronous read port.
module imem_bank
    import ibus_imem_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS = IMEM_WORDS_DEFAULT
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_WORDS)-1:0] widx,
    input  u32                           wdata,
    input  logic [$clog2(MEM_WORDS)-1:0] ridx,
    output u32                           rdata
);

    u32 mem_q [MEM_WORDS];

    // Load port write; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[widx] <= wdata;
        end
    end

    assign rdata = mem_q[ridx];

endmodule

// File: rtl/ibus_imem_responder.sv
// ibus target: captures a fetch request, waits LATENCY cycles, returns one registered response pulse.
module ibus_imem_responder
    import ibus_imem_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS = IMEM_WORDS_DEFAULT,
    parameter u64          BASE_ADDR = PCINIT,
    parameter int unsigned LATENCY   = 32'd2
) (
    input  logic                         clk,
    input  logic                         rst,
    ibus_imem_responder_if.slave         bus,
    input  logic                         load_en,
    input  logic [$clog2(MEM_WORDS)-1:0] load_idx,
    input  u32                           load_data
);

    localparam int unsigned IDX_W   = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W   = (LATENCY == 32'd0) ? 32'd1 : $clog2(LATENCY + 32'd1);
    localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);
    localparam u64          SPAN    = 64'(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_t;

    imem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    u64               req_addr_q, req_addr_d;
    logic             ok_q, ok_d;
    u32               data_q, data_d;
    logic             fault_q, fault_d;

    u64               look_addr_s;
    u64               off_s;
    logic             bad_s;
    logic [IDX_W-1:0] rd_idx_s;
    u32               rd_data_s;
    logic             enter_resp_s;

    imem_bank #(.MEM_WORDS(MEM_WORDS)) u_bank (
        .clk   (clk),
        .we    (load_en),
        .widx  (load_idx),
        .wdata (load_data),
        .ridx  (rd_idx_s),
        .rdata (rd_data_s)
    );

    // Address that will be served if RESP is entered this cycle: the live bus address when
    // leaving IDLE, otherwise the latched one (equal to the bus address whenever WAIT expires).
    always_comb begin
        if (state_q == IDLE) begin
            look_addr_s = bus.ibus_req.addr;
        end else begin
            look_addr_s = req_addr_q;
        end
        off_s    = look_addr_s - BASE_ADDR;
        bad_s    = (look_addr_s[1:0] != 2'b00) || (look_addr_s < BASE_ADDR) ||
                   ((off_s >> 2'd2) >= SPAN);
        rd_idx_s = off_s[2 +: IDX_W];
    end

    // Next-state, wait counter and registered response contents.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_addr_d   = req_addr_q;
        ok_d         = 1'b0;
        data_d       = data_q;
        fault_d      = 1'b0;
        enter_resp_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ibus_req.valid) begin
                    req_addr_d = bus.ibus_req.addr;
                    cnt_d      = LAT_C;
                    if (LATENCY == 32'd0) begin
                        state_d      = RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (!bus.ibus_req.valid) begin
                    state_d = IDLE;
                end else if (bus.ibus_req.addr != req_addr_q) begin
                    // Redirect restarts the full wait from this edge.
                    req_addr_d = bus.ibus_req.addr;
                    cnt_d      = LAT_C;
                    state_d    = WAIT;
                end else if (cnt_q == CNT_ONE) begin
                    cnt_d        = cnt_q - CNT_ONE;
                    state_d      = RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (enter_resp_s) begin
            ok_d    = 1'b1;
            fault_d = bad_s;
            data_d  = bad_s ? 32'd0 : rd_data_s;
        end else begin
            ok_d    = 1'b0;
            fault_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset; memory is left untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            req_addr_q <= 64'd0;
            ok_q       <= 1'b0;
            data_q     <= 32'd0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_addr_q <= req_addr_d;
            ok_q       <= ok_d;
            data_q     <= data_d;
            fault_q    <= fault_d;
        end
    end

    assign bus.ibus_resp = ibus_resp_t'{ok_q, ok_q, data_q};
    assign bus.fault     = fault_q;

endmodule

// File: tb/tb_ibus_imem_responder.sv
// Directed bench: LATENCY=2 responder plus a LATENCY=0 build sharing the load port.
module tb_ibus_imem_responder;
    import ibus_imem_responder_pkg::*;

    localparam int unsigned MW   = 32'd1024;
    localparam u64          BASE = PCINIT;

    logic       clk;
    logic       rst;
    logic       load_en;
    logic [9:0] load_idx;
    u32         load_data;
    int         checks;
    int         failures;

    ibus_imem_responder_if bus2();
    ibus_imem_responder_if bus0();

    ibus_imem_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(32'd2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data)
    );

    ibus_imem_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(32'd0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic load_word(input logic [9:0] idx, input u32 data);
        @(negedge clk);
        load_en   = 1'b1;
        load_idx  = idx;
        load_data = data;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus2.ibus_req = ibus_req_t'{1'b0, 64'd0};
        bus0.ibus_req = ibus_req_t'{1'b0, 64'd0};
        load_en = 1'b1; load_idx = 10'd0; load_data = 32'h0000_0093;
        @(negedge clk);
        load_en = 1'b0;
        @(negedge clk);
        checks++; if ({bus2.ibus_resp.addr_ok, bus2.ibus_resp.data_ok} !== 2'b00) begin failures++; $display("FAIL reset_ok2 got=%b exp=00", {bus2.ibus_resp.addr_ok, bus2.ibus_resp.data_ok}); end
        checks++; if (bus2.ibus_resp.data !== 32'd0) begin failures++; $display("FAIL reset_data2 got=%h exp=0", bus2.ibus_resp.data); end
        checks++; if (bus2.fault !== 1'b0) begin failures++; $display("FAIL reset_fault2 got=%b exp=0", bus2.fault); end
        checks++; if ({bus0.ibus_resp.addr_ok, bus0.ibus_resp.data_ok, bus0.fault} !== 3'b000) begin failures++; $display("FAIL reset_ok0 got=%b exp=000", {bus0.ibus_resp.addr_ok, bus0.ibus_resp.data_ok, bus0.fault}); end
        checks++; if (bus0.ibus_resp.data !== 32'd0) begin failures++; $display("FAIL reset_data0 got=%h exp=0", bus0.ibus_resp.data); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic e;
        bus2.ibus_req = ibus_req_t'{1'b1, BASE};
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            e = (k == 3);
            checks++; if ({bus2.ibus_resp.addr_ok, bus2.ibus_resp.data_ok} !== {e, e}) begin failures++; $display("FAIL single_ok k=%0d got=%b exp=%b", k, {bus2.ibus_resp.addr_ok, bus2.ibus_resp.data_ok}, {e, e}); end
            checks++; if (bus2.ibus_resp.data !== ((k >= 3) ? 32'h0000_0093 : 32'd0)) begin failures++; $display("FAIL single_data k=%0d got=%h", k, bus2.ibus_resp.data); end
            checks++; if (bus2.fault !== 1'b0) begin failures++; $display("FAIL single_fault k=%0d got=%b exp=0", k, bus2.fault); end
            if (k == 3) begin
                bus2.ibus_req.valid = 1'b0;
            end
        end
    endtask

    task automatic test_held();
        logic e;
        bus2.ibus_req = ibus_req_t'{1'b1, BASE + 64'd4};
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            e = ((k % 4) == 3);
            checks++; if ({bus2.ibus_resp.addr_ok, bus2.ibus_resp.data_ok} !== {e, e}) begin failures++; $display("FAIL held_ok k=%0d got=%b exp=%b", k, {bus2.ibus_resp.addr_ok, bus2.ibus_resp.data_ok}, {e, e}); end
            if (e) begin
                checks++; if (bus2.ibus_resp.data !== 32'hA1A1_0001) begin failures++; $display("FAIL held_data k=%0d got=%h exp=a1a10001", k, bus2.ibus_resp.data); end
            end
        end
        bus2.ibus_req.valid = 1'b0;
    endtask

    task automatic test_redirect();
        logic e;
        bus2.ibus_req = ibus_req_t'{1'b1, BASE};
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            e = (k == 4);
            checks++; if ({bus2.ibus_resp.addr_ok, bus2.ibus_resp.data_ok} !== {e, e}) begin failures++; $display("FAIL redirect_ok k=%0d got=%b exp=%b", k, {bus2.ibus_resp.addr_ok, bus2.ibus_resp.data_ok}, {e, e}); end
            if (k == 1) begin
                bus2.ibus_req.addr = BASE + 64'd8;
            end
            if (k == 4) begin
                checks++; if (bus2.ibus_resp.data !== 32'hB2B2_0002) begin failures++; $display("FAIL redirect_data got=%h exp=b2b20002", bus2.ibus_resp.data); end
                bus2.ibus_req.valid = 1'b0;
            end
        end
    endtask

    task automatic test_abandon();
        logic e;
        bus2.ibus_req = ibus_req_t'{1'b1, BASE + 64'd12};
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++; if ({bus2.ibus_resp.addr_ok, bus2.ibus_resp.data_ok} !== 2'b00) begin failures++; $display("FAIL abandon_ok k=%0d got=%b exp=00", k, {bus2.ibus_resp.addr_ok, bus2.ibus_resp.data_ok}); end
            bus2.ibus_req.valid = 1'b0;
        end
        bus2.ibus_req = ibus_req_t'{1'b1, BASE + 64'd12};
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            e = (k == 3);
            checks++; if ({bus2.ibus_resp.addr_ok, bus2.ibus_resp.data_ok} !== {e, e}) begin failures++; $display("FAIL abandon_next_ok k=%0d got=%b exp=%b", k, {bus2.ibus_resp.addr_ok, bus2.ibus_resp.data_ok}, {e, e}); end
            if (e) begin
                checks++; if (bus2.ibus_resp.data !== 32'hC3C3_0003) begin failures++; $display("FAIL abandon_next_data got=%h exp=c3c30003", bus2.ibus_resp.data); end
                bus2.ibus_req.valid = 1'b0;
            end
        end
    endtask

    task automatic test_fault();
        u64   addrs  [6];
        u32   datas  [6];
        logic faults [6];
        logic e;
        addrs[0] = BASE + 64'd4092;  datas[0] = 32'hDEAD_03FF; faults[0] = 1'b0;
        addrs[1] = BASE + 64'd2;     datas[1] = 32'd0;         faults[1] = 1'b1;
        addrs[2] = BASE + 64'd4;     datas[2] = 32'hA1A1_0001; faults[2] = 1'b0;
        addrs[3] = BASE - 64'd4;     datas[3] = 32'd0;         faults[3] = 1'b1;
        addrs[4] = BASE + 64'd8;     datas[4] = 32'hB2B2_0002; faults[4] = 1'b0;
        addrs[5] = BASE + 64'd4096;  datas[5] = 32'd0;         faults[5] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus2.ibus_req = ibus_req_t'{1'b1, addrs[i]};
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                e = (k == 3);
                checks++; if ({bus2.ibus_resp.addr_ok, bus2.ibus_resp.data_ok, bus2.fault} !== {e, e, e & faults[i]}) begin failures++; $display("FAIL fault_hs i=%0d k=%0d got=%b exp=%b", i, k, {bus2.ibus_resp.addr_ok, bus2.ibus_resp.data_ok, bus2.fault}, {e, e, e & faults[i]}); end
                if (e) begin
                    checks++; if (bus2.ibus_resp.data !== datas[i]) begin failures++; $display("FAIL fault_data i=%0d got=%h exp=%h", i, bus2.ibus_resp.data, datas[i]); end
                    bus2.ibus_req.valid = 1'b0;
                end
            end
        end
    endtask

    task automatic test_read_during_load();
        logic e;
        bus2.ibus_req = ibus_req_t'{1'b1, BASE + 64'd12};
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            e = (k == 3);
            load_en = 1'b0;
            checks++; if ({bus2.ibus_resp.addr_ok, bus2.ibus_resp.data_ok} !== {e, e}) begin failures++; $display("FAIL rdl_ok k=%0d got=%b exp=%b", k, {bus2.ibus_resp.addr_ok, bus2.ibus_resp.data_ok}, {e, e}); end
            if (k == 2) begin
                load_en = 1'b1; load_idx = 10'd3; load_data = 32'h5A5A_5A5A;
            end
            if (e) begin
                checks++; if (bus2.ibus_resp.data !== 32'hC3C3_0003) begin failures++; $display("FAIL rdl_old got=%h exp=c3c30003", bus2.ibus_resp.data); end
                bus2.ibus_req.valid = 1'b0;
            end
        end
        bus2.ibus_req = ibus_req_t'{1'b1, BASE + 64'd12};
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 3) begin
                checks++; if ({bus2.ibus_resp.data_ok, bus2.ibus_resp.data} !== {1'b1, 32'h5A5A_5A5A}) begin failures++; $display("FAIL rdl_new got=%b/%h exp=1/5a5a5a5a", bus2.ibus_resp.data_ok, bus2.ibus_resp.data); end
                bus2.ibus_req.valid = 1'b0;
            end
        end
    endtask

    task automatic test_latency0();
        logic e;
        bus0.ibus_req = ibus_req_t'{1'b1, BASE + 64'd4};
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            e = (k == 1) || (k == 3);
            checks++; if ({bus0.ibus_resp.addr_ok, bus0.ibus_resp.data_ok} !== {e, e}) begin failures++; $display("FAIL lat0_ok k=%0d got=%b exp=%b", k, {bus0.ibus_resp.addr_ok, bus0.ibus_resp.data_ok}, {e, e}); end
            if (k == 1) begin
                checks++; if ({bus0.fault, bus0.ibus_resp.data} !== {1'b0, 32'hA1A1_0001}) begin failures++; $display("FAIL lat0_data got=%b/%h exp=0/a1a10001", bus0.fault, bus0.ibus_resp.data); end
            end
            if (k == 3) begin
                bus0.ibus_req.valid = 1'b0;
            end
        end
        bus0.ibus_req = ibus_req_t'{1'b1, BASE - 64'd4};
        @(negedge clk);
        bus0.ibus_req.valid = 1'b0;
        checks++; if ({bus0.ibus_resp.data_ok, bus0.fault, bus0.ibus_resp.data} !== {1'b1, 1'b1, 32'd0}) begin failures++; $display("FAIL lat0_fault got=%b/%b/%h exp=1/1/0", bus0.ibus_resp.data_ok, bus0.fault, bus0.ibus_resp.data); end
        @(negedge clk);
        bus0.ibus_req = ibus_req_t'{1'b1, BASE + 64'd8};
        @(negedge clk);
        bus0.ibus_req.valid = 1'b0;
        checks++; if ({bus0.ibus_resp.data_ok, bus0.ibus_resp.data} !== {1'b1, 32'hB2B2_0002}) begin failures++; $display("FAIL lat0_next got=%b/%h exp=1/b2b20002", bus0.ibus_resp.data_ok, bus0.ibus_resp.data); end
    endtask

    task automatic test_reset_mid();
        bus2.ibus_req = ibus_req_t'{1'b1, BASE};
        @(negedge clk);
        checks++; if (bus2.ibus_resp.data_ok !== 1'b0) begin failures++; $display("FAIL rstmid_pre got=%b exp=0", bus2.ibus_resp.data_ok); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({bus2.ibus_resp.addr_ok, bus2.ibus_resp.data_ok, bus2.fault, bus2.ibus_resp.data} !== {3'b000, 32'd0}) begin failures++; $display("FAIL rstmid_out2 got=%b/%h exp=000/0", {bus2.ibus_resp.addr_ok, bus2.ibus_resp.data_ok, bus2.fault}, bus2.ibus_resp.data); end
        checks++; if (bus0.ibus_resp.data !== 32'd0) begin failures++; $display("FAIL rstmid_out0 got=%h exp=0", bus0.ibus_resp.data); end
        rst = 1'b0;
        bus2.ibus_req.valid = 1'b0;
        for (int k = 3; k <= 6; k++) begin
            @(negedge clk);
            checks++; if ({bus2.ibus_resp.addr_ok, bus2.ibus_resp.data_ok} !== 2'b00) begin failures++; $display("FAIL rstmid_noresp k=%0d got=%b exp=00", k, {bus2.ibus_resp.addr_ok, bus2.ibus_resp.data_ok}); end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        load_en   = 1'b0;
        load_idx  = 10'd0;
        load_data = 32'd0;
        test_reset();
        load_word(10'd1,    32'hA1A1_0001);
        load_word(10'd2,    32'hB2B2_0002);
        load_word(10'd3,    32'hC3C3_0003);
        load_word(10'd1023, 32'hDEAD_03FF);
        @(negedge clk);
        test_single();
        test_held();
        test_redirect();
        test_abandon();
        test_fault();
        test_read_during_load();
        test_latency0();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
